// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards operands from EX/MEM and MEM/WB, maps opcodes
// to ALU operands/function codes and presents them registered with valid/ready.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iValid,
    output logic            oReady,
    input  logic [6:0]      iOpcode,
    input  logic [2:0]      iFunct3,
    input  logic [6:0]      iFunct7,
    input  logic [4:0]      iRs1,
    input  logic [4:0]      iRs2,
    input  logic [4:0]      iRd,
    input  logic [XLEN-1:0] iImm,
    input  logic [XLEN-1:0] iPc,
    input  logic [XLEN-1:0] iRs1Data,
    input  logic [XLEN-1:0] iRs2Data,
    input  logic            iExMemRegWrite,
    input  logic            iExMemIsLoad,
    input  logic [4:0]      iExMemRd,
    input  logic [XLEN-1:0] iExMemData,
    input  logic            iMemWbRegWrite,
    input  logic [4:0]      iMemWbRd,
    input  logic [XLEN-1:0] iMemWbData,
    input  logic            iFlush,
    output logic            oValid,
    input  logic            iReady,
    output logic [XLEN-1:0] oDataA,
    output logic [XLEN-1:0] oDataB,
    output logic [2:0]      oFunct3,
    output logic [6:0]      oFunct7,
    output logic [XLEN-1:0] oStoreData,
    output logic [4:0]      oRd,
    output logic            oRegWrite,
    output logic            oIllegal,
    output logic [XLEN-1:0] oPc
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // EX/MEM has priority over MEM/WB; x0 always reads as zero
    function automatic logic [XLEN-1:0] fwdSel(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rfData,
        input logic            exMemRegWrite,
        input logic [4:0]      exMemRd,
        input logic [XLEN-1:0] exMemData,
        input logic            memWbRegWrite,
        input logic [4:0]      memWbRd,
        input logic [XLEN-1:0] memWbData
    );
        logic [XLEN-1:0] res;
        if (idx == 5'd0) begin
            res = {XLEN{1'b0}};
        end else if (exMemRegWrite && (exMemRd == idx)) begin
            res = exMemData;
        end else if (memWbRegWrite && (memWbRd == idx)) begin
            res = memWbData;
        end else begin
            res = rfData;
        end
        return res;
    endfunction

    logic [XLEN-1:0] fwd1_s;
    logic [XLEN-1:0] fwd2_s;
    logic            useRs1_s;
    logic            useRs2_s;
    logic [XLEN-1:0] dataA_s;
    logic [XLEN-1:0] dataB_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] storeData_s;
    logic            writesRd_s;
    logic            illegal_s;
    logic            loadUse_s;
    logic            accept_s;

    assign fwd1_s = fwdSel(iRs1, iRs1Data, iExMemRegWrite, iExMemRd, iExMemData,
                           iMemWbRegWrite, iMemWbRd, iMemWbData);
    assign fwd2_s = fwdSel(iRs2, iRs2Data, iExMemRegWrite, iExMemRd, iExMemData,
                           iMemWbRegWrite, iMemWbRd, iMemWbData);

    // Opcode decode into ALU operands, function codes and source usage
    always_comb begin
        useRs1_s    = 1'b0;
        useRs2_s    = 1'b0;
        dataA_s     = {XLEN{1'b0}};
        dataB_s     = {XLEN{1'b0}};
        funct3_s    = 3'b000;
        funct7_s    = 7'b0000000;
        storeData_s = {XLEN{1'b0}};
        writesRd_s  = 1'b0;
        illegal_s   = 1'b0;
        case (iOpcode)
            OP_REG: begin
                useRs1_s   = 1'b1;
                useRs2_s   = 1'b1;
                dataA_s    = fwd1_s;
                dataB_s    = fwd2_s;
                funct3_s   = iFunct3;
                funct7_s   = iFunct7;
                writesRd_s = 1'b1;
            end
            OP_IMM: begin
                useRs1_s   = 1'b1;
                dataA_s    = fwd1_s;
                dataB_s    = iImm;
                funct3_s   = iFunct3;
                // only shifts carry a funct7; ADDI must never turn into SUB
                if ((iFunct3 == 3'b001) || (iFunct3 == 3'b101)) begin
                    funct7_s = iImm[11:5];
                end else begin
                    funct7_s = 7'b0000000;
                end
                writesRd_s = 1'b1;
            end
            OP_LUI: begin
                dataB_s    = iImm;
                writesRd_s = 1'b1;
            end
            OP_AUIPC: begin
                dataA_s    = iPc;
                dataB_s    = iImm;
                writesRd_s = 1'b1;
            end
            OP_LOAD: begin
                useRs1_s   = 1'b1;
                dataA_s    = fwd1_s;
                dataB_s    = iImm;
                writesRd_s = 1'b1;
            end
            OP_STORE: begin
                useRs1_s    = 1'b1;
                useRs2_s    = 1'b1;
                dataA_s     = fwd1_s;
                dataB_s     = iImm;
                storeData_s = fwd2_s;
            end
            OP_BRANCH: begin
                useRs1_s = 1'b1;
                useRs2_s = 1'b1;
                dataA_s  = fwd1_s;
                dataB_s  = fwd2_s;
                case (iFunct3[2:1])
                    2'b10: funct3_s = 3'b010;
                    2'b11: funct3_s = 3'b011;
                    default: begin
                        funct3_s = 3'b000;
                        funct7_s = 7'b0100000;
                    end
                endcase
            end
            OP_JAL: begin
                dataA_s    = iPc;
                dataB_s    = {{(XLEN-3){1'b0}}, 3'b100};
                writesRd_s = 1'b1;
            end
            OP_JALR: begin
                useRs1_s   = 1'b1;
                dataA_s    = iPc;
                dataB_s    = {{(XLEN-3){1'b0}}, 3'b100};
                writesRd_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign loadUse_s = iExMemIsLoad && iExMemRegWrite && (iExMemRd != 5'd0) &&
                       ((useRs1_s && (iExMemRd == iRs1)) || (useRs2_s && (iExMemRd == iRs2)));
    assign oReady    = !loadUse_s && (!oValid || iReady);
    assign accept_s  = iValid && oReady;

    // Pipeline register: reset, flush, load on accept, drain on consume, else hold
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid     <= 1'b0;
            oDataA     <= {XLEN{1'b0}};
            oDataB     <= {XLEN{1'b0}};
            oFunct3    <= 3'b000;
            oFunct7    <= 7'b0000000;
            oStoreData <= {XLEN{1'b0}};
            oRd        <= 5'd0;
            oRegWrite  <= 1'b0;
            oIllegal   <= 1'b0;
            oPc        <= {XLEN{1'b0}};
        end else if (iFlush) begin
            oValid <= 1'b0;
        end else if (accept_s) begin
            oValid     <= 1'b1;
            oDataA     <= dataA_s;
            oDataB     <= dataB_s;
            oFunct3    <= funct3_s;
            oFunct7    <= funct7_s;
            oStoreData <= storeData_s;
            oRd        <= iRd;
            oRegWrite  <= writesRd_s && (iRd != 5'd0);
            oIllegal   <= illegal_s;
            oPc        <= iPc;
        end else if (iReady) begin
            oValid <= 1'b0;
        end else begin
            oValid <= oValid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: decode map, forwarding,
// load-use stall, backpressure, flush and reset.
module tb_id_ex_stage;

    logic        iClk = 1'b0;
    logic        iRst, iValid, oReady, iFlush, oValid, iReady;
    logic [6:0]  iOpcode, iFunct7, oFunct7;
    logic [2:0]  iFunct3, oFunct3;
    logic [4:0]  iRs1, iRs2, iRd, iExMemRd, iMemWbRd, oRd;
    logic [31:0] iImm, iPc, iRs1Data, iRs2Data, iExMemData, iMemWbData;
    logic        iExMemRegWrite, iExMemIsLoad, iMemWbRegWrite;
    logic [31:0] oDataA, oDataB, oStoreData, oPc;
    logic        oRegWrite, oIllegal;

    int chkCount = 0;
    int errCount = 0;

    always #5 iClk = ~iClk;

    id_ex_stage #(.XLEN(32)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iOpcode(iOpcode), .iFunct3(iFunct3), .iFunct7(iFunct7),
        .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd), .iImm(iImm), .iPc(iPc),
        .iRs1Data(iRs1Data), .iRs2Data(iRs2Data),
        .iExMemRegWrite(iExMemRegWrite), .iExMemIsLoad(iExMemIsLoad),
        .iExMemRd(iExMemRd), .iExMemData(iExMemData),
        .iMemWbRegWrite(iMemWbRegWrite), .iMemWbRd(iMemWbRd), .iMemWbData(iMemWbData),
        .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
        .oDataA(oDataA), .oDataB(oDataB), .oFunct3(oFunct3), .oFunct7(oFunct7),
        .oStoreData(oStoreData), .oRd(oRd), .oRegWrite(oRegWrite),
        .oIllegal(oIllegal), .oPc(oPc)
    );

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] imm, input logic [31:0] pc,
                            input logic [31:0] d1, input logic [31:0] d2);
        iOpcode = op; iFunct3 = f3; iFunct7 = f7; iRs1 = rs1; iRs2 = rs2; iRd = rd;
        iImm = imm; iPc = pc; iRs1Data = d1; iRs2Data = d2;
    endtask

    task automatic clearFwd();
        iExMemRegWrite = 1'b0; iExMemIsLoad = 1'b0; iExMemRd = 5'd0; iExMemData = 32'd0;
        iMemWbRegWrite = 1'b0; iMemWbRd = 5'd0; iMemWbData = 32'd0;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iValid = 1'b0; iReady = 1'b1; iFlush = 1'b0;
        clearFwd();
        setInstr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0);
        step(); step();
        iRst = 1'b0;
        chkCount++; if (oValid !== 1'b0) begin errCount++; $display("FAIL reset_valid: got %b exp 0", oValid); end
        chkCount++; if (oRegWrite !== 1'b0 || oIllegal !== 1'b0) begin errCount++; $display("FAIL reset_flags: got rw=%b ill=%b exp 0 0", oRegWrite, oIllegal); end
        chkCount++; if (oDataA !== 32'd0 || oDataB !== 32'd0) begin errCount++; $display("FAIL reset_data: got %h %h exp 0 0", oDataA, oDataB); end
        chkCount++; if (oReady !== 1'b1) begin errCount++; $display("FAIL reset_ready: got %b exp 1", oReady); end
    endtask

    task automatic test_add();
        setInstr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd0, 32'h40, 32'd5, 32'd7);
        iValid = 1'b1;
        step();
        iValid = 1'b0;
        chkCount++; if (oValid !== 1'b1) begin errCount++; $display("FAIL add_valid: got %b exp 1", oValid); end
        chkCount++; if (oDataA !== 32'd5 || oDataB !== 32'd7) begin errCount++; $display("FAIL add_ops: got %h %h exp 5 7", oDataA, oDataB); end
        chkCount++; if (oFunct3 !== 3'b000 || oFunct7 !== 7'd0) begin errCount++; $display("FAIL add_funct: got %b %b exp 000 0000000", oFunct3, oFunct7); end
        chkCount++; if (oRegWrite !== 1'b1 || oRd !== 5'd3 || oPc !== 32'h40) begin errCount++; $display("FAIL add_rd: got rw=%b rd=%0d pc=%h exp 1 3 40", oRegWrite, oRd, oPc); end
        step();
        chkCount++; if (oValid !== 1'b0) begin errCount++; $display("FAIL add_drain: got %b exp 0", oValid); end
    endtask

    task automatic test_opimm();
        setInstr(7'b0010011, 3'b000, 7'b0100000, 5'd1, 5'd0, 5'd4, 32'hFFFF_FFFF, 32'd0, 32'd10, 32'd0);
        iValid = 1'b1;
        step();
        chkCount++; if (oDataA !== 32'd10 || oDataB !== 32'hFFFF_FFFF) begin errCount++; $display("FAIL addi_ops: got %h %h exp a ffffffff", oDataA, oDataB); end
        chkCount++; if (oFunct7 !== 7'b0000000) begin errCount++; $display("FAIL addi_funct7: got %b exp 0000000", oFunct7); end
        setInstr(7'b0010011, 3'b101, 7'b0000000, 5'd1, 5'd0, 5'd4, 32'h0000_0405, 32'd0, 32'd10, 32'd0);
        step();
        iValid = 1'b0;
        chkCount++; if (oValid !== 1'b1 || oDataB !== 32'h405) begin errCount++; $display("FAIL srai_b2b: got v=%b b=%h exp 1 405", oValid, oDataB); end
        chkCount++; if (oFunct7 !== 7'b0100000 || oFunct3 !== 3'b101) begin errCount++; $display("FAIL srai_funct: got %b %b exp 101 0100000", oFunct3, oFunct7); end
    endtask

    task automatic test_forward();
        clearFwd();
        iExMemRegWrite = 1'b1; iExMemRd = 5'd1; iExMemData = 32'hAA;
        iMemWbRegWrite = 1'b1; iMemWbRd = 5'd1; iMemWbData = 32'hBB;
        setInstr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'hCC, 32'h22);
        iValid = 1'b1;
        step();
        chkCount++; if (oDataA !== 32'hAA || oDataB !== 32'h22) begin errCount++; $display("FAIL fwd_exmem: got %h %h exp aa 22", oDataA, oDataB); end
        iExMemRegWrite = 1'b0;
        step();
        chkCount++; if (oDataA !== 32'hBB) begin errCount++; $display("FAIL fwd_memwb: got %h exp bb", oDataA); end
        iExMemRegWrite = 1'b1; iExMemRd = 5'd0; iExMemData = 32'h55;
        iMemWbRd = 5'd0;
        setInstr(7'b0110011, 3'b000, 7'b0000000, 5'd0, 5'd2, 5'd3, 32'd0, 32'd0, 32'hCC, 32'h22);
        step();
        iValid = 1'b0;
        chkCount++; if (oDataA !== 32'd0) begin errCount++; $display("FAIL fwd_x0: got %h exp 0", oDataA); end
        clearFwd();
    endtask

    task automatic test_load_use();
        clearFwd();
        iExMemRegWrite = 1'b1; iExMemIsLoad = 1'b1; iExMemRd = 5'd4; iExMemData = 32'h44;
        setInstr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd4, 5'd5, 32'd0, 32'd0, 32'd3, 32'h99);
        iValid = 1'b1;
        #1;
        chkCount++; if (oReady !== 1'b0) begin errCount++; $display("FAIL lu_ready0: got %b exp 0", oReady); end
        step(); step();
        chkCount++; if (oReady !== 1'b0 || oValid !== 1'b0) begin errCount++; $display("FAIL lu_stall: got rdy=%b v=%b exp 0 0", oReady, oValid); end
        iExMemIsLoad = 1'b0;
        #1;
        chkCount++; if (oReady !== 1'b1) begin errCount++; $display("FAIL lu_release: got %b exp 1", oReady); end
        step();
        iValid = 1'b0;
        chkCount++; if (oValid !== 1'b1 || oDataB !== 32'h44 || oDataA !== 32'd3) begin errCount++; $display("FAIL lu_accept: got v=%b a=%h b=%h exp 1 3 44", oValid, oDataA, oDataB); end
        clearFwd();
    endtask

    task automatic test_stall_flush();
        iValid = 1'b0; iReady = 1'b1;
        step();
        setInstr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd5, 32'd7);
        iValid = 1'b1; iReady = 1'b0;
        step();
        setInstr(7'b0110011, 3'b111, 7'b0000000, 5'd1, 5'd2, 5'd6, 32'd0, 32'd0, 32'h11, 32'h22);
        #1;
        chkCount++; if (oReady !== 1'b0) begin errCount++; $display("FAIL bp_ready: got %b exp 0", oReady); end
        step(); step();
        chkCount++; if (oValid !== 1'b1 || oDataA !== 32'd5 || oDataB !== 32'd7 || oFunct3 !== 3'b000 || oRd !== 5'd3) begin
            errCount++; $display("FAIL bp_hold: got v=%b a=%h b=%h f3=%b rd=%0d exp 1 5 7 000 3", oValid, oDataA, oDataB, oFunct3, oRd); end
        iFlush = 1'b1;
        step();
        chkCount++; if (oValid !== 1'b0) begin errCount++; $display("FAIL flush_held: got %b exp 0", oValid); end
        iReady = 1'b1;
        step();
        chkCount++; if (oValid !== 1'b0) begin errCount++; $display("FAIL flush_incoming: got %b exp 0", oValid); end
        iFlush = 1'b0; iValid = 1'b0;
    endtask

    task automatic test_branch_jal_illegal();
        iValid = 1'b1; iReady = 1'b1;
        setInstr(7'b1100011, 3'b110, 7'b0000000, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd8, 32'd9);
        step();
        chkCount++; if (oFunct3 !== 3'b011 || oFunct7 !== 7'd0 || oDataA !== 32'd8 || oDataB !== 32'd9 || oRegWrite !== 1'b0) begin
            errCount++; $display("FAIL bltu: got f3=%b f7=%b a=%h b=%h rw=%b exp 011 0 8 9 0", oFunct3, oFunct7, oDataA, oDataB, oRegWrite); end
        setInstr(7'b1100011, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd8, 32'd9);
        step();
        chkCount++; if (oFunct3 !== 3'b000 || oFunct7 !== 7'b0100000) begin errCount++; $display("FAIL bne: got %b %b exp 000 0100000", oFunct3, oFunct7); end
        setInstr(7'b1101111, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd1, 32'h800, 32'h100, 32'd0, 32'd0);
        step();
        chkCount++; if (oDataA !== 32'h100 || oDataB !== 32'd4 || oRegWrite !== 1'b1) begin errCount++; $display("FAIL jal: got a=%h b=%h rw=%b exp 100 4 1", oDataA, oDataB, oRegWrite); end
        setInstr(7'b0010111, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd2, 32'h1000, 32'h200, 32'd0, 32'd0);
        step();
        chkCount++; if (oDataA !== 32'h200 || oDataB !== 32'h1000) begin errCount++; $display("FAIL auipc: got %h %h exp 200 1000", oDataA, oDataB); end
        setInstr(7'b0100011, 3'b010, 7'b0000000, 5'd1, 5'd2, 5'd7, 32'h8, 32'd0, 32'h30, 32'hDEAD);
        step();
        chkCount++; if (oDataA !== 32'h30 || oDataB !== 32'h8 || oStoreData !== 32'hDEAD || oRegWrite !== 1'b0) begin
            errCount++; $display("FAIL store: got a=%h b=%h sd=%h rw=%b exp 30 8 dead 0", oDataA, oDataB, oStoreData, oRegWrite); end
        setInstr(7'b1111111, 3'b101, 7'b0100000, 5'd1, 5'd2, 5'd5, 32'h7, 32'h300, 32'h1, 32'h2);
        step();
        chkCount++; if (oIllegal !== 1'b1 || oRegWrite !== 1'b0 || oDataA !== 32'd0 || oDataB !== 32'd0 || oFunct3 !== 3'b000 || oFunct7 !== 7'd0) begin
            errCount++; $display("FAIL illegal: got ill=%b rw=%b a=%h b=%h f3=%b f7=%b exp 1 0 0 0 000 0", oIllegal, oRegWrite, oDataA, oDataB, oFunct3, oFunct7); end
        setInstr(7'b0110111, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd0, 32'h1234_5000, 32'd0, 32'd0, 32'd0);
        step();
        chkCount++; if (oDataA !== 32'd0 || oDataB !== 32'h1234_5000 || oRegWrite !== 1'b0 || oIllegal !== 1'b0) begin
            errCount++; $display("FAIL lui_x0: got a=%h b=%h rw=%b ill=%b exp 0 12345000 0 0", oDataA, oDataB, oRegWrite, oIllegal); end
        iValid = 1'b0;
    endtask

    task automatic test_mid_reset();
        setInstr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd5, 32'd7);
        iValid = 1'b1; iReady = 1'b1;
        step();
        iValid = 1'b0; iReady = 1'b0; iRst = 1'b1;
        step();
        iRst = 1'b0;
        chkCount++; if (oValid !== 1'b0 || oRegWrite !== 1'b0 || oDataA !== 32'd0) begin
            errCount++; $display("FAIL mid_reset: got v=%b rw=%b a=%h exp 0 0 0", oValid, oRegWrite, oDataA); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_opimm();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_branch_jal_illegal();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", chkCount, errCount);
        $finish;
    end

endmodule
